// File: rtl/nf10_axis_sim_stim_gen.sv
// AXI4-Stream packet source: programmed packet count, deterministic payload, NetFPGA-10G
// tuser sideband, tready backpressure, and a completed-packet counter with activity pulse.
module nf10_axis_sim_stim_gen #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT           = 8'h01,
    parameter logic [7:0]  C_DST_PORT           = 8'h04,
    parameter int unsigned C_IFG_CYCLES         = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               start,
    input  logic                               stop,
    input  logic [7:0]                         num_pkts,
    input  logic [15:0]                        pkt_len,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [7:0]                         counter,
    output logic                               activity_send,
    output logic                               busy
);
    localparam int unsigned StrbW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned Lanes = C_M_AXIS_DATA_WIDTH / 32;
    localparam int unsigned GapW  = (C_IFG_CYCLES > 1) ? $clog2(C_IFG_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(C_IFG_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                          r_state, w_state_nxt;
    logic [15:0]                     r_len, w_len_nxt;
    logic [7:0]                      r_num, w_num_nxt;
    logic [7:0]                      r_pkt, w_pkt_nxt;
    logic [10:0]                     r_beat, w_beat_nxt;
    logic [GapW-1:0]                 r_gap, w_gap_nxt;
    logic                            r_stop_req, w_stop_req_nxt;
    logic [7:0]                      r_cnt, w_cnt_nxt;
    logic                            r_act, w_act_nxt;
    logic                            r_busy;
    logic                            r_tvalid, w_tvalid_nxt;
    logic                            r_tlast, w_tlast_nxt;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  r_tdata, w_tdata_nxt;
    logic [StrbW-1:0]                r_tstrb, w_tstrb_nxt;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] r_tuser, w_tuser_nxt;
    logic [16:0]                     w_beats;
    logic                            w_last_beat;

    function automatic logic [C_M_AXIS_DATA_WIDTH-1:0] f_data(input logic [7:0] pkt,
                                                              input logic [7:0] beat);
        logic [C_M_AXIS_DATA_WIDTH-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            d[32*k +: 32] = {pkt, beat, 8'(k), 8'hA5};
        end
        return d;
    endfunction

    function automatic logic [StrbW-1:0] f_strb(input logic last, input logic [4:0] rem);
        if (!last || rem == 5'd0) return '1;
        return (StrbW'(1) << rem) - StrbW'(1);
    endfunction

    // Beat count of the packet that will be on the bus next cycle.
    assign w_beats     = (17'(w_len_nxt) + 17'd31) >> 5;
    assign w_last_beat = ({6'd0, w_beat_nxt} == (w_beats - 17'd1));

    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_num_nxt      = r_num;
        w_pkt_nxt      = r_pkt;
        w_beat_nxt     = r_beat;
        w_gap_nxt      = r_gap;
        w_stop_req_nxt = r_stop_req;
        w_cnt_nxt      = r_cnt;
        w_act_nxt      = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_stop_req_nxt = 1'b0;
                if (start) begin
                    w_state_nxt    = StSend;
                    w_len_nxt      = (pkt_len == 16'd0) ? 16'd64 : pkt_len;
                    w_num_nxt      = num_pkts;
                    w_pkt_nxt      = '0;
                    w_beat_nxt     = '0;
                    w_stop_req_nxt = stop;
                end
            end
            StSend: begin
                // Remember a stop seen anywhere in the packet so a short pulse still ends the run.
                w_stop_req_nxt = r_stop_req | stop;
                if (m_axis_tready) begin
                    if (!r_tlast) begin
                        w_beat_nxt = r_beat + 11'd1;
                    end else begin
                        w_cnt_nxt  = r_cnt + 8'd1;
                        w_act_nxt  = 1'b1;
                        w_pkt_nxt  = r_pkt + 8'd1;
                        w_beat_nxt = '0;
                        w_gap_nxt  = '0;
                        if (stop || r_stop_req || (r_num != 8'd0 && w_pkt_nxt == r_num)) begin
                            w_state_nxt = StIdle;
                        end else if (C_IFG_CYCLES != 0) begin
                            w_state_nxt = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (stop || r_stop_req) begin
                    w_state_nxt = StIdle;
                end else if (r_gap == GapLast) begin
                    w_state_nxt = StSend;
                end else begin
                    w_gap_nxt = r_gap + GapW'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Bus contents are a pure function of the next beat, so a stalled beat re-registers unchanged.
    always_comb begin
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_tdata_nxt  = '0;
        w_tstrb_nxt  = '0;
        w_tuser_nxt  = '0;
        if (w_state_nxt == StSend) begin
            w_tvalid_nxt       = 1'b1;
            w_tlast_nxt        = w_last_beat;
            w_tdata_nxt        = f_data(w_pkt_nxt, w_beat_nxt[7:0]);
            w_tstrb_nxt        = f_strb(w_last_beat, w_len_nxt[4:0]);
            w_tuser_nxt[31:0]  = {C_DST_PORT, C_SRC_PORT, w_len_nxt};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_num      <= '0;
            r_pkt      <= '0;
            r_beat     <= '0;
            r_gap      <= '0;
            r_stop_req <= 1'b0;
            r_cnt      <= '0;
            r_act      <= 1'b0;
            r_busy     <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_tstrb    <= '0;
            r_tuser    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_num      <= w_num_nxt;
            r_pkt      <= w_pkt_nxt;
            r_beat     <= w_beat_nxt;
            r_gap      <= w_gap_nxt;
            r_stop_req <= w_stop_req_nxt;
            r_cnt      <= w_cnt_nxt;
            r_act      <= w_act_nxt;
            r_busy     <= (w_state_nxt != StIdle);
            r_tvalid   <= w_tvalid_nxt;
            r_tlast    <= w_tlast_nxt;
            r_tdata    <= w_tdata_nxt;
            r_tstrb    <= w_tstrb_nxt;
            r_tuser    <= w_tuser_nxt;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tstrb  = r_tstrb;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign counter       = r_cnt;
    assign activity_send = r_act;
    assign busy          = r_busy;

endmodule

// File: tb/tb_nf10_axis_sim_stim_gen.sv
// Bench for nf10_axis_sim_stim_gen: a transaction-level model checks every cycle, directed
// tests pin literal values. Instance 0 uses a 4-cycle gap, instance 1 runs back-to-back.
module tb_nf10_axis_sim_stim_gen;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         tready = 1'b1;
    logic         sel = 1'b0;
    logic [7:0]   num_pkts = '0;
    logic [15:0]  pkt_len = '0;
    logic         start0, start1;

    logic [255:0] d0_tdata, d1_tdata, tdata;
    logic [31:0]  d0_tstrb, d1_tstrb, tstrb;
    logic [127:0] d0_tuser, d1_tuser, tuser;
    logic         d0_tvalid, d1_tvalid, tvalid;
    logic         d0_tlast, d1_tlast, tlast;
    logic [7:0]   d0_cnt, d1_cnt, cnt;
    logic         d0_act, d1_act, act;
    logic         d0_busy, d1_busy, busy;

    int n_cmp = 0;
    int n_fail = 0;
    int n_xfer = 0;

    always #5 aclk = ~aclk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign tdata  = sel ? d1_tdata : d0_tdata;
    assign tstrb  = sel ? d1_tstrb : d0_tstrb;
    assign tuser  = sel ? d1_tuser : d0_tuser;
    assign tvalid = sel ? d1_tvalid : d0_tvalid;
    assign tlast  = sel ? d1_tlast : d0_tlast;
    assign cnt    = sel ? d1_cnt : d0_cnt;
    assign act    = sel ? d1_act : d0_act;
    assign busy   = sel ? d1_busy : d0_busy;

    nf10_axis_sim_stim_gen #(.C_IFG_CYCLES(4)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .start(start0), .stop(stop),
        .num_pkts(num_pkts), .pkt_len(pkt_len),
        .m_axis_tdata(d0_tdata), .m_axis_tstrb(d0_tstrb), .m_axis_tuser(d0_tuser),
        .m_axis_tvalid(d0_tvalid), .m_axis_tready(tready), .m_axis_tlast(d0_tlast),
        .counter(d0_cnt), .activity_send(d0_act), .busy(d0_busy)
    );

    nf10_axis_sim_stim_gen #(.C_IFG_CYCLES(0)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .start(start1), .stop(stop),
        .num_pkts(num_pkts), .pkt_len(pkt_len),
        .m_axis_tdata(d1_tdata), .m_axis_tstrb(d1_tstrb), .m_axis_tuser(d1_tuser),
        .m_axis_tvalid(d1_tvalid), .m_axis_tready(tready), .m_axis_tlast(d1_tlast),
        .counter(d1_cnt), .activity_send(d1_act), .busy(d1_busy)
    );

    task automatic chk(input string name, input logic [255:0] actual, input logic [255:0] req);
        n_cmp++;
        if (actual !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, actual, req, $time);
        end
    endtask

    function automatic logic [255:0] exp_data(input int pkt, input int beat);
        logic [255:0] d;
        logic [7:0] p, b, k8;
        p = 8'(pkt % 256);
        b = 8'(beat % 256);
        for (int k = 0; k < 8; k++) begin
            k8 = 8'(k);
            d[32*k +: 32] = {p, b, k8, 8'hA5};
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_strb(input bit last, input int len);
        int r;
        r = len % 32;
        if (!last || r == 0) return 32'hFFFF_FFFF;
        return (32'd1 << r) - 32'd1;
    endfunction

    // Transaction model: phase 0 idle, 1 sending, 2 inter-packet gap.
    int m_ph = 0;
    int m_len, m_num, m_pkt, m_beat, m_gap, m_ifg, m_beats;
    logic [7:0] m_cnt = '0;
    bit m_act = 1'b0;
    bit m_last;

    always @(negedge aclk) begin
        m_ifg = sel ? 0 : 4;
        if (!aresetn) begin
            m_ph  = 0;
            m_cnt = '0;
            m_act = 1'b0;
            chk("rst_tvalid", tvalid, 0);
            chk("rst_counter", cnt, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("counter", cnt, m_cnt);
            chk("activity", act, m_act);
            m_act = 1'b0;
            case (m_ph)
                0: begin
                    chk("idle_tvalid", tvalid, 0);
                    chk("idle_busy", busy, 0);
                    if (start) begin
                        m_len  = (pkt_len == 0) ? 64 : int'(pkt_len);
                        m_num  = int'(num_pkts);
                        m_pkt  = 0;
                        m_beat = 0;
                        m_ph   = 1;
                    end
                end
                1: begin
                    m_beats = (m_len + 31) / 32;
                    m_last  = (m_beat == m_beats - 1);
                    chk("send_tvalid", tvalid, 1);
                    chk("send_busy", busy, 1);
                    chk("tdata", tdata, exp_data(m_pkt, m_beat));
                    chk("tstrb", tstrb, exp_strb(m_last, m_len));
                    chk("tuser", tuser, {96'd0, 8'h04, 8'h01, 16'(m_len)});
                    chk("tlast", tlast, m_last);
                    if (tready) begin
                        n_xfer++;
                        if (m_last) begin
                            m_cnt  = m_cnt + 8'd1;
                            m_act  = 1'b1;
                            m_pkt  = m_pkt + 1;
                            m_beat = 0;
                            if (stop || (m_num != 0 && m_pkt == m_num)) begin
                                m_ph = 0;
                            end else if (m_ifg > 0) begin
                                m_ph  = 2;
                                m_gap = 0;
                            end
                        end else begin
                            m_beat = m_beat + 1;
                        end
                    end
                end
                default: begin
                    chk("gap_tvalid", tvalid, 0);
                    chk("gap_busy", busy, 1);
                    if (stop) begin
                        m_ph = 0;
                    end else begin
                        m_gap = m_gap + 1;
                        if (m_gap == m_ifg) m_ph = 1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] len, input logic [7:0] num);
        pkt_len  = len;
        num_pkts = num;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (rnd_ready) tready = 1'($urandom_range(0, 1));
            tick();
        end
        tready = 1'b1;
        chk("wait_idle_timeout", done, 1);
    endtask

    int x0;

    initial begin
        #1 aresetn = 1'b0;
        #3;
        chk("reset_tvalid", d0_tvalid, 0);
        chk("reset_tlast", d0_tlast, 0);
        chk("reset_tdata", d0_tdata, 0);
        chk("reset_tstrb", d0_tstrb, 0);
        chk("reset_tuser", d0_tuser, 0);
        chk("reset_counter", d0_cnt, 0);
        chk("reset_activity", d0_act, 0);
        chk("reset_busy", d0_busy, 0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) tick();

        // Single 64-byte packet
        pulse_start(16'd64, 8'd1);
        chk("p1_b0_lane0", tdata[31:0], 32'h0000_00A5);
        chk("p1_b0_lane7", tdata[255:224], 32'h0000_07A5);
        chk("p1_b0_tlast", tlast, 0);
        chk("p1_b0_tstrb", tstrb, 32'hFFFF_FFFF);
        chk("p1_b0_tuser", tuser[31:0], 32'h0401_0040);
        tick();
        chk("p1_b1_lane0", tdata[31:0], 32'h0001_00A5);
        chk("p1_b1_tlast", tlast, 1);
        chk("p1_b1_tstrb", tstrb, 32'hFFFF_FFFF);
        tick();
        chk("p1_done_busy", busy, 0);
        chk("p1_done_act", act, 1);
        chk("p1_done_counter", cnt, 8'd1);
        tick();
        chk("p1_act_once", act, 0);

        // Partial last beats
        pulse_start(16'd60, 8'd1);
        chk("len60_b0_tstrb", tstrb, 32'hFFFF_FFFF);
        tick();
        chk("len60_b1_tstrb", tstrb, 32'h0FFF_FFFF);
        chk("len60_b1_tlast", tlast, 1);
        wait_idle(1'b0);
        pulse_start(16'd1, 8'd1);
        chk("len1_tlast", tlast, 1);
        chk("len1_tstrb", tstrb, 32'h0000_0001);
        wait_idle(1'b0);
        pulse_start(16'd0, 8'd1);
        chk("len0_tuser", tuser[15:0], 16'd64);
        wait_idle(1'b0);
        chk("after_partial_counter", cnt, 8'd4);

        // Backpressure
        x0 = n_xfer;
        pulse_start(16'd96, 8'd1);
        wait_idle(1'b1);
        chk("bp1_xfers", n_xfer - x0, 3);
        x0 = n_xfer;
        pulse_start(16'd96, 8'd2);
        wait_idle(1'b1);
        chk("bp2_xfers", n_xfer - x0, 6);
        chk("bp_counter", cnt, 8'd7);

        // Start together with stop: one packet only
        stop = 1'b1;
        pulse_start(16'd64, 8'd5);
        wait_idle(1'b0);
        stop = 1'b0;
        chk("startstop_counter", cnt, 8'd8);

        // Stop mid-packet, then stop inside the gap
        pulse_start(16'd128, 8'd0);
        repeat (2) tick();
        stop = 1'b1;
        wait_idle(1'b0);
        stop = 1'b0;
        chk("stop_mid_counter", cnt, 8'd9);
        pulse_start(16'd128, 8'd0);
        repeat (6) tick();
        chk("stop_gap_tvalid", tvalid, 0);
        stop = 1'b1;
        wait_idle(1'b0);
        stop = 1'b0;
        chk("stop_gap_counter", cnt, 8'd10);

        // Asynchronous reset during beat 1 of the second packet
        pulse_start(16'd128, 8'd0);
        repeat (9) tick();
        chk("pre_rst_lane0", tdata[31:0], 32'h0101_00A5);
        #2 aresetn = 1'b0;
        #1;
        chk("async_tvalid", d0_tvalid, 0);
        chk("async_tlast", d0_tlast, 0);
        chk("async_counter", d0_cnt, 0);
        chk("async_busy", d0_busy, 0);
        tick();
        aresetn = 1'b1;
        tick();
        pulse_start(16'd64, 8'd1);
        chk("fresh_lane0", tdata[31:0], 32'h0000_00A5);
        wait_idle(1'b0);
        chk("fresh_counter", cnt, 8'd1);

        // Start while busy is ignored
        pulse_start(16'd64, 8'd3);
        tick();
        pulse_start(16'd32, 8'd1);
        wait_idle(1'b0);
        chk("ignored_start_counter", cnt, 8'd4);

        // Back-to-back continuous run on the zero-gap instance
        aresetn = 1'b0;
        tick();
        sel = 1'b1;
        aresetn = 1'b1;
        tick();
        pulse_start(16'd32, 8'd0);
        repeat (255) tick();
        chk("wrap_counter_ff", cnt, 8'hFF);
        chk("wrap_lane0_ff", tdata[31:0], 32'hFF00_00A5);
        tick();
        chk("wrap_counter_00", cnt, 8'h00);
        chk("wrap_lane0_00", tdata[31:0], 32'h0000_00A5);
        stop = 1'b1;
        wait_idle(1'b0);
        stop = 1'b0;
        chk("cont_stop_counter", cnt, 8'h01);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nf10_axis_sim_stim_gen.md
Name: nf10_axis_sim_stim_gen

Overview:
- Synthesizable AXI4-Stream packet source. It is the transmit-side counterpart to the AXI-Stream record/sink used in reference_nic simulation benches.
- Generates a programmed number of packets. Payload is deterministic, sideband uses the NetFPGA-10G tuser format, and the source honours tready backpressure.
- Drives a DUT slave port, e.g. an sram_fifo s_axis. Exposes a packet counter and an activity pulse that mirror the sink's counter/activity_rec.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, tdata width; fixed at 256, so the tstrb width is 32.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width.
- C_SRC_PORT, 8'h01, value driven on tuser[23:16].
- C_DST_PORT, 8'h04, value driven on tuser[31:24].
- C_IFG_CYCLES, 4, idle cycles with tvalid low between packets; 0 means back-to-back.

Ports:
- aclk  in  1  sole clock; all logic rising-edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stop  in  1  level; finish current packet, then return to IDLE.
- num_pkts  in  8  packets per run, latched on start; 0 means continuous until stop.
- pkt_len  in  16  packet length in bytes, latched on start; 0 is treated as 64.
- m_axis_tdata  out  256  payload.
- m_axis_tstrb  out  32  byte enables.
- m_axis_tuser  out  128  sideband.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of packet.
- counter  out  8  packets completed, wrapping.
- activity_send  out  1  one-cycle pulse per completed packet.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State goes to IDLE.
  - tvalid, tlast, tdata, tstrb, tuser, counter, activity_send and busy all reset to 0.
  - Beat, packet and gap counters clear.
  - Reset mid-packet abandons the packet; no tlast is emitted.
- All outputs are registered.
- Beat count: beats = ceil(len/32) with len = latched pkt_len, 11-bit beat counter. Maximum length 65535 gives 2048 beats.
- States:
  - IDLE: busy=0, tvalid=0. On start=1 at edge N: latch len and num_pkts, clear pkt_idx and beat, enter SEND. tvalid=1 from cycle N+1.
  - SEND: tvalid=1. A beat transfers on a cycle with tvalid&&tready.
    - Non-last transfer: beat increments.
    - Last transfer (tlast=1): counter increments (255 wraps to 0), activity_send=1 next cycle only, pkt_idx increments.
    - Transition after the last transfer:
      - IDLE if stop=1 sampled that cycle, or pkt_idx+1 == num_pkts with num_pkts != 0.
      - Otherwise GAP if C_IFG_CYCLES > 0.
      - Otherwise SEND with beat=0, with tvalid continuously high.
  - GAP: tvalid=0 for exactly C_IFG_CYCLES cycles, then SEND, or IDLE if stop=1 at any point in GAP.
- Handshake rules:
  - While tvalid=1 and tready=0, tdata/tstrb/tuser/tlast hold stable.
  - tvalid never drops mid-packet.
  - stop never truncates a packet.
- tdata: 32-bit lane k (bits 32k+31:32k, k=0..7) of beat b = {pkt_idx[7:0], b[7:0], k[7:0], 8'hA5}.
- tstrb:
  - Non-last beats: all ones.
  - Last beat: r = len mod 32; 32'hFFFFFFFF if r==0, else (1<<r)-1.
- tuser, held constant for every beat of a packet:
  - [15:0] = len.
  - [23:16] = C_SRC_PORT.
  - [31:24] = C_DST_PORT.
  - [127:32] = 0.
- tlast is high only on beat index beats-1. A 1-beat packet has tlast on its first beat.
- start during busy is ignored. Simultaneous start and stop in IDLE: start is taken, and stop applies at the first packet end.
- Between tvalid phases the outputs are don't-care, but are driven to 0.

Test Plan:
- Single packet: pkt_len=64, num_pkts=1, tready=1, start at cycle 10.
  - Required: tvalid at cycles 11-12. Beat0 lane0=32'h000000A5, lane7=32'h000007A5. tlast only at cycle 12, tstrb=FFFFFFFF both beats, tuser[31:0]=32'h04010040.
  - After completion: counter=1, activity_send high at cycle 13 only, busy=0 at 13.
- Partial last beat: pkt_len=60 -> 2 beats, last tstrb=32'h0FFFFFFF. pkt_len=1 -> 1 beat, tlast=1, tstrb=32'h00000001.
- Backpressure: pkt_len=96, tready toggled randomly.
  - Required: outputs stable whenever tvalid&&!tready. Exactly 3 transfers with beat fields 0,1,2.
  - With C_IFG_CYCLES=4 and 2 packets: exactly 4 cycles of tvalid=0 between packets.
- Wrap and continuous mode: num_pkts=0, pkt_len=32, C_IFG_CYCLES=0, tready=1.
  - Required: tvalid continuously high, counter 255->0 at packet 256, pkt_idx field wraps.
  - stop asserted mid-run: the current packet completes, then IDLE.
- Reset mid-packet: aresetn low during beat 1 of a 128-byte packet.
  - Required: tvalid/tlast/counter/busy go to 0 immediately, without waiting for aclk.
  - After release, start produces a fresh packet with pkt_idx=0.
- Ignored start: start pulsed while busy -> no change to latched len or num_pkts, and total packet count matches the original num_pkts.
